// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encrypt controller around a single shared round datapath.
// Latency: block accepted at edge T, cipher valid after edge T+10, 12-cycle minimum spacing.
// Backpressure: holds DONE with the cipher stable until out_ready; in_ready is low outside IDLE.

package aes_iter_ctrl_pkg;
    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box computed as multiplicative inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction
endpackage

// SubBytes over all 16 bytes
module sub_Byte (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar i = 0; i < 16; i++) begin : g_sb
        assign dout[8*i +: 8] = aes_iter_ctrl_pkg::sbox(din[8*i +: 8]);
    end
endmodule

// ShiftRows; byte k sits at bits [127-8k -: 8], column-major (row = k%4)
module shiftrow (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar k = 0; k < 16; k++) begin : g_sr
        localparam int R   = k % 4;
        localparam int C   = k / 4;
        localparam int SRC = R + 4 * ((C + R) % 4);
        assign dout[127 - 8*k -: 8] = din[127 - 8*SRC -: 8];
    end
endmodule

// MixColumns on each of the four columns
module Mixcolumn (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    import aes_iter_ctrl_pkg::xt;
    for (genvar c = 0; c < 4; c++) begin : g_mc
        logic [7:0] a0, a1, a2, a3;
        assign a0 = din[127 - 32*c      -: 8];
        assign a1 = din[127 - 32*c - 8  -: 8];
        assign a2 = din[127 - 32*c - 16 -: 8];
        assign a3 = din[127 - 32*c - 24 -: 8];
        assign dout[127 - 32*c      -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        assign dout[127 - 32*c - 8  -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        assign dout[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        assign dout[127 - 32*c - 24 -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
endmodule

// AddRoundKey
module Addroundkey (
    input  logic [127:0] din,
    input  logic [127:0] key,
    output logic [127:0] dout
);
    assign dout = din ^ key;
endmodule

// One step of the AES-128 key schedule: round key r from round key r-1
module keyexpansion (
    input  logic [127:0] prev,
    input  logic [3:0]   r,
    output logic [127:0] next
);
    import aes_iter_ctrl_pkg::sbox;
    logic [7:0]  rcon;
    logic [31:0] w3, t, n0, n1, n2, n3;

    // Round constant lookup
    always_comb begin
        rcon = 8'h00;
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w3 = prev[31:0];
    // RotWord then SubWord then Rcon
    assign t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign n0 = prev[127:96] ^ t;
    assign n1 = prev[95:64]  ^ n0;
    assign n2 = prev[63:32]  ^ n1;
    assign n3 = w3           ^ n2;
    assign next = {n0, n1, n2, n3};
endmodule

module aes_iter_ctrl #(
    parameter logic [127:0] DEFAULT_KEY = 128'h0123456789abcdef0123456789abcdef
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher,
    output logic         busy,
    output logic [3:0]   round
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, rkey_q, base_key_q, cipher_q;
    logic [3:0]   round_q;
    logic [127:0] k0, sb, sr, mc, nk, ark_in, ark_out;
    logic         last_round;

    assign last_round = (round_q == 4'd10);
    // A key loaded in the accepting cycle applies to that block
    assign k0     = key_load ? key_in : base_key_q;
    // Final round skips MixColumns
    assign ark_in = last_round ? sr : mc;

    sub_Byte     u_sb (.din(state_q), .dout(sb));
    shiftrow     u_sr (.din(sb), .dout(sr));
    Mixcolumn    u_mc (.din(sr), .dout(mc));
    keyexpansion u_ke (.prev(rkey_q), .r(round_q), .next(nk));
    Addroundkey  u_ak (.din(ark_in), .key(nk), .dout(ark_out));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    // Next-state decode
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (in_valid)   fsm_d = ROUND;
            ROUND:   if (last_round) fsm_d = DONE;
            DONE:    if (out_ready)  fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Datapath registers: key load, whitening, round iteration, cipher capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= '0;
            rkey_q     <= '0;
            base_key_q <= DEFAULT_KEY;
            cipher_q   <= '0;
            round_q    <= 4'd0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (key_load) base_key_q <= key_in;
                    if (in_valid) begin
                        state_q <= plaintext ^ k0;
                        rkey_q  <= k0;
                        round_q <= 4'd1;
                    end
                end
                ROUND: begin
                    rkey_q <= nk;
                    if (last_round) begin
                        cipher_q <= ark_out;
                    end else begin
                        state_q <= ark_out;
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: if (out_ready) round_q <= 4'd0;
                default: ;
            endcase
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);
    assign cipher    = cipher_q;
    assign round     = round_q;
endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Directed bench for aes_iter_ctrl using published AES-128 vectors.
// Latency: checks acceptance-to-out_valid distance and block spacing.
// Backpressure: holds out_ready low and checks cipher/in_ready stability.
module tb_aes_iter_ctrl;
    localparam logic [127:0] K_A  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, key_load, out_valid, out_ready, busy;
    logic [127:0] plaintext, key_in, cipher;
    logic [3:0]   round;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int ov_cyc = 0;

    logic [127:0] ecb_pt [4];
    logic [127:0] ecb_ct [4];

    // Reset default overridden to a key with a known vector so the revert is observable
    aes_iter_ctrl #(.DEFAULT_KEY(K_A)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key_load(key_load), .key_in(key_in),
        .out_valid(out_valid), .out_ready(out_ready), .cipher(cipher),
        .busy(busy), .round(round)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_blk(input logic [127:0] pt, input logic kl, input logic [127:0] k);
        in_valid  = 1'b1;
        plaintext = pt;
        key_load  = kl;
        key_in    = k;
        tick();
        in_valid  = 1'b0;
        key_load  = 1'b0;
    endtask

    // n = edges already elapsed since (and including) the accepting edge
    task automatic finish_blk(input string tag, input logic [127:0] exp, input int n0);
        int n = n0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        ov_cyc = cyc;
        chk({tag, "_lat"}, 128'(n), 128'd11);
        chk({tag, "_ct"}, cipher, exp);
    endtask

    initial begin
        int n, bad, prev_ov;
        ecb_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        ecb_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        ecb_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        ecb_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        ecb_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        ecb_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        ecb_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        ecb_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;

        rst = 1'b1; in_valid = 1'b0; key_load = 1'b0; out_ready = 1'b1;
        plaintext = '0; key_in = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_round", 128'(round), 128'd0);
        chk("rst_cipher", cipher, 128'd0);

        // Simultaneous key load and block
        start_blk(P_B, 1'b1, K_B);
        chk("t2_busy", 128'(busy), 128'd1);
        chk("t2_in_ready", 128'(in_ready), 128'd0);
        chk("t2_round1", 128'(round), 128'd1);
        finish_blk("t2", C_B, 1);
        chk("t2_done_round", 128'(round), 128'd10);
        tick();
        chk("t2_idle_in_ready", 128'(in_ready), 128'd1);
        chk("t2_idle_round", 128'(round), 128'd0);
        chk("t2_cipher_kept", cipher, C_B);

        // Backpressure: key K_B persists from the previous load
        out_ready = 1'b0;
        start_blk(P_B, 1'b0, '0);
        finish_blk("t3a", C_B, 1);
        in_valid  = 1'b1;
        plaintext = ecb_pt[0];
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cipher !== C_B || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        chk("t3_hold_bad_cycles", 128'(bad), 128'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_in_ready_after", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        chk("t3_second_accepted", 128'(round), 128'd1);
        finish_blk("t3b", ecb_ct[0], 1);
        out_ready = 1'b1;
        tick();

        // Explicit key load then FIPS-197 C.1
        key_load = 1'b1; key_in = K_A;
        tick();
        key_load = 1'b0;
        start_blk(P_A, 1'b0, '0);
        finish_blk("t1", C_A, 1);
        tick();

        // Key load during round 5 is ignored
        start_blk(P_A, 1'b0, '0);
        n = 1;
        while (round != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_round5", 128'(round), 128'd5);
        key_load = 1'b1; key_in = K_B;
        tick();
        n++;
        key_load = 1'b0;
        finish_blk("t4a", C_A, n);
        tick();
        start_blk(P_A, 1'b0, '0);
        finish_blk("t4b", C_A, 1);
        tick();

        // Reset during round 7 drops the block and reverts the key
        key_load = 1'b1; key_in = K_B;
        tick();
        key_load = 1'b0;
        start_blk(P_B, 1'b0, '0);
        n = 1;
        while (round != 4'd7 && n < 20) begin
            tick();
            n++;
        end
        chk("t5_round7", 128'(round), 128'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_out_valid", 128'(out_valid), 128'd0);
        chk("t5_busy", 128'(busy), 128'd0);
        chk("t5_round", 128'(round), 128'd0);
        chk("t5_cipher", cipher, 128'd0);
        chk("t5_in_ready", 128'(in_ready), 128'd1);
        start_blk(P_A, 1'b0, '0);
        finish_blk("t5", C_A, 1);
        tick();

        // Back-to-back throughput, SP 800-38A ECB vectors
        key_load = 1'b1; key_in = K_B;
        tick();
        key_load = 1'b0;
        prev_ov  = 0;
        for (int b = 0; b < 4; b++) begin
            plaintext = ecb_pt[b];
            in_valid  = 1'b1;
            tick();
            finish_blk($sformatf("t6_b%0d", b), ecb_ct[b], 1);
            if (b > 0) chk($sformatf("t6_spacing%0d", b), 128'(ov_cyc - prev_ov), 128'd12);
            prev_ov = ov_cyc;
            tick();
            chk($sformatf("t6_ov_pulse%0d", b), 128'(out_valid), 128'd0);
        end
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/aes_iter_ctrl.md
Name: aes_iter_ctrl

Overview:
- Iterative AES-128 encryption controller: one shared round datapath, sequenced over 10 cycles per block, instead of ten unrolled round copies.
- Instantiates the team's existing round primitives once each: sub_Byte, shiftrow, Mixcolumn, Addroundkey, keyexpansion.
- Owns the round counter, state and round-key registers, the key-load path, and valid/ready handshakes on input and output.
- Sits between a block source (e.g. DMA/FIFO) and the cipher consumer.

Parameters:
DEFAULT_KEY, 128'h0123456789abcdef0123456789abcdef, cipher key in force after reset until the first key_load.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  plaintext block offered
in_ready  output  1  controller can accept a block (high only in IDLE)
plaintext  input  128  block to encrypt, sampled on in_valid && in_ready
key_load  input  1  load key_in as the new cipher key (honoured only in IDLE)
key_in  input  128  new cipher key
out_valid  output  1  cipher holds a finished block
out_ready  input  1  consumer accepts cipher
cipher  output  128  encrypted block, stable while out_valid
busy  output  1  high in ROUND or DONE
round  output  4  current round index 0..10 (debug)

Behaviour:
- Reset (rst high at an edge):
  - state_q = 0, rkey_q = 0, base_key_q = DEFAULT_KEY.
  - round = 0, cipher = 0, out_valid = 0, busy = 0, FSM = IDLE.
  - Holds mid-operation too: the block in flight is dropped, no out_valid is produced, and the loaded key reverts to DEFAULT_KEY.
- keyexpansion(prev, r, next): r = 1..10 produces round key r from round key r-1; round key 0 = base_key_q.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - key_load = 1: base_key_q <= key_in.
  - in_valid = 1: state_q <= plaintext ^ K0, rkey_q <= K0, round <= 1, go to ROUND.
    - K0 = key_in if key_load is high in the same cycle, else base_key_q. A simultaneous load therefore applies to that block.
- ROUND (round = r, 1..10):
  - Every cycle: nk = keyexpansion(rkey_q, r); rkey_q <= nk.
  - r < 10: state_q <= Addroundkey(Mixcolumn(shiftrow(sub_Byte(state_q))), nk); round <= r+1.
  - r = 10: cipher <= Addroundkey(shiftrow(sub_Byte(state_q)), nk); go to DONE.
  - in_ready = 0; key_load and in_valid are ignored (not queued).
- DONE:
  - out_valid = 1; cipher and round (=10) are held.
  - out_ready = 1: out_valid <= 0, round <= 0, go to IDLE. cipher keeps its last value.
  - out_ready = 0: stay in DONE indefinitely (backpressure). No new block is accepted and in_ready stays 0.
- Latency:
  - Block accepted at edge T; ten round edges T+1..T+10; out_valid is high in the cycle after edge T+10.
  - Minimum spacing is 12 cycles per block with out_ready tied high.
- Width rules: all XOR/round operations are 128-bit. The byte order is that of the existing primitives (byte 0 = bits 127:120). round is 4-bit and never exceeds 10.
- in_ready, out_valid and busy are decoded from registered FSM state only; there is no combinational path from inputs to these outputs.

Test Plan:
1. Key load then FIPS-197 C.1 vector.
   - Stimulus: in IDLE, key_load with key_in = 000102030405060708090a0b0c0d0e0f; then in_valid with plaintext = 00112233445566778899aabbccddeeff.
   - Required: cipher = 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 11 cycles after acceptance.
2. Simultaneous key_load and in_valid.
   - Stimulus: key_in = 2b7e151628aed2a6abf7158809cf4f3c, plaintext = 3243f6a8885a308d313198a2e0370734, both in the same IDLE cycle.
   - Required: cipher = 3925841d02dc09fbdc118597196a0b32.
3. Backpressure.
   - Stimulus: hold out_ready = 0 for 20 cycles after out_valid; keep in_valid high with a new block.
   - Required: cipher stable and in_ready = 0 throughout. After out_ready pulses, in_ready = 1 the next cycle and the second block is accepted.
4. Key load while busy.
   - Stimulus: pulse key_load with a different key during round 5.
   - Required: the current block's result is unchanged and the next block still uses the old key.
5. Reset mid-operation.
   - Stimulus: assert rst during round 7.
   - Required: the next cycle shows out_valid = 0, busy = 0, round = 0, cipher = 0, in_ready = 1. A following block uses DEFAULT_KEY.
6. Back-to-back throughput.
   - Stimulus: out_ready tied high, in_valid continuously high, 4 blocks.
   - Required: 4 correct ciphers, out_valid pulses spaced exactly 12 cycles apart.
